// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential non-restoring divider.
package div_pkg;

    localparam int unsigned DefaultDw = 16;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StIter = 3'd1,
        StFix  = 3'd2,
        StSgn  = 3'd3,
        StDone = 3'd4
    } div_state_e;

endpackage

// File: rtl/div_nr_step.sv
// One combinational non-restoring iteration: subtract the divisor when the running
// remainder is non-negative, add it back when negative.
module div_nr_step #(
    parameter int unsigned DW = 16
) (
    input  logic [DW:0]   prem_i,
    input  logic [DW-1:0] dv_i,
    input  logic          cbit_i,
    output logic [DW-1:0] diff_o,
    output logic          qbit_o,
    output logic          cbit_o
);

    logic [DW:0] sum;

    always_comb begin
        sum    = cbit_i ? (prem_i + {1'b0, dv_i}) : (prem_i - {1'b0, dv_i});
        diff_o = sum[DW-1:0];
        qbit_o = ~sum[DW];
        cbit_o = sum[DW];
    end

endmodule

// File: rtl/div_nr_seq.sv
// Sequential 2*DW / DW divider, one quotient bit per clock, signed or unsigned per operation,
// with valid/ready on both sides and divide-by-zero / overflow reporting.
module div_nr_seq
    import div_pkg::*;
#(
    parameter int unsigned DW = DefaultDw
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] dd,
    input  logic [DW-1:0]   dv,
    input  logic            sgn,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   qt,
    output logic [DW-1:0]   rm,
    output logic            dbz,
    output logic            ovf
);

    localparam int unsigned KW = $clog2(DW);
    localparam logic [DW-1:0] QNegMax = {1'b1, {(DW-1){1'b0}}};

    div_state_e      state_q, state_d;
    logic [2*DW-1:0] ireg_q;
    logic [DW-1:0]   dv_q;
    logic [KW-1:0]   kreg_q;
    logic            cbit_q, sgn_q, qneg_q, rneg_q, early_q;
    logic [DW-1:0]   qt_q, rm_q;
    logic            dbz_q, ovf_q;

    logic            dd_neg, dv_neg, acc_dbz, acc_ovf;
    logic [2*DW-1:0] dd_mag;
    logic [DW-1:0]   dv_mag;

    always_comb begin
        dd_neg  = sgn & dd[2*DW-1];
        dv_neg  = sgn & dv[DW-1];
        dd_mag  = dd_neg ? -dd : dd;
        dv_mag  = dv_neg ? -dv : dv;
        acc_dbz = (dv == '0);
        acc_ovf = (dd_mag[2*DW-1:DW] >= dv_mag);
    end

    // FIX reuses the step in add mode on the bare remainder.
    logic [DW:0]   step_prem;
    logic          step_cin;
    logic [DW-1:0] step_diff;
    logic          step_qbit, step_cout;

    always_comb begin
        step_prem = ireg_q[2*DW-1:DW-1];
        step_cin  = cbit_q;
        if (state_q == StFix) begin
            step_prem = {1'b0, ireg_q[2*DW-1:DW]};
            step_cin  = 1'b1;
        end
    end

    div_nr_step #(
        .DW(DW)
    ) u_step (
        .prem_i (step_prem),
        .dv_i   (dv_q),
        .cbit_i (step_cin),
        .diff_o (step_diff),
        .qbit_o (step_qbit),
        .cbit_o (step_cout)
    );

    logic [DW-1:0] qmag, rmag;
    logic          sgn_ovf;

    always_comb begin
        qmag    = ireg_q[DW-1:0];
        rmag    = ireg_q[2*DW-1:DW];
        sgn_ovf = sgn_q & (qneg_q ? (qmag > QNegMax) : qmag[DW-1]);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Flagged results still pass through SGN, so they appear one clock after accept.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = (acc_dbz || acc_ovf) ? StSgn : StIter;
                end
            end
            StIter: if (kreg_q == '0) state_d = StFix;
            StFix:  state_d = StSgn;
            StSgn:  state_d = StDone;
            StDone: if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        qt        = qt_q;
        rm        = rm_q;
        dbz       = dbz_q;
        ovf       = ovf_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ireg_q  <= '0;
            dv_q    <= '0;
            kreg_q  <= '0;
            cbit_q  <= 1'b0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            early_q <= 1'b0;
            qt_q    <= '0;
            rm_q    <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        ireg_q  <= dd_mag;
                        dv_q    <= dv_mag;
                        sgn_q   <= sgn;
                        qneg_q  <= dd_neg ^ dv_neg;
                        rneg_q  <= dd_neg;
                        cbit_q  <= 1'b0;
                        kreg_q  <= KW'(DW - 1);
                        early_q <= acc_dbz | acc_ovf;
                        dbz_q   <= acc_dbz;
                        ovf_q   <= ~acc_dbz & acc_ovf;
                        qt_q    <= '1;
                        rm_q    <= acc_dbz ? dd[DW-1:0] : '0;
                    end
                end
                StIter: begin
                    ireg_q <= {step_diff, ireg_q[DW-2:0], step_qbit};
                    cbit_q <= step_cout;
                    if (kreg_q != '0) kreg_q <= kreg_q - KW'(1);
                end
                StFix: begin
                    if (cbit_q) ireg_q[2*DW-1:DW] <= step_diff;
                end
                StSgn: begin
                    if (!early_q) begin
                        if (sgn_ovf) begin
                            ovf_q <= 1'b1;
                            qt_q  <= '1;
                            rm_q  <= '0;
                        end else begin
                            qt_q <= qneg_q ? -qmag : qmag;
                            rm_q <= rneg_q ? -rmag : rmag;
                        end
                    end
                end
                StDone: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_nr_seq.sv
// Scoreboard bench for div_nr_seq (DW=16): directed and random operations, back-pressure,
// and reset during an iteration.
module tb_div_nr_seq;

    localparam int unsigned DW = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] dd = '0;
    logic [15:0] dv = '0;
    logic        sgn = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] qt, rm;
    logic        dbz, ovf;

    div_nr_seq #(
        .DW(DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dd        (dd),
        .dv        (dv),
        .sgn       (sgn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .qt        (qt),
        .rm        (rm),
        .dbz       (dbz),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] qt;
        logic [15:0] rm;
        logic        dbz;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   rise_cyc = 0;
    int   acc_cyc = 0;
    logic ov_prev = 1'b0;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (out_valid && !ov_prev) rise_cyc = cyc;
        ov_prev = out_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] q, input logic [15:0] r, input logic z,
                                input logic o, input int l);
        exp_t e;
        e.qt = q; e.rm = r; e.dbz = z; e.ovf = o; e.lat = l;
        return e;
    endfunction

    // Reference: signed division in SV truncates toward zero, remainder follows dividend.
    function automatic exp_t model(input logic [31:0] a, input logic [15:0] b, input logic s);
        longint na, nb, ua, ub, q, r;
        exp_t   e;
        e = mk(16'h0, 16'h0, 1'b0, 1'b0, DW + 2);
        if (b == 16'h0) return mk(16'hFFFF, a[15:0], 1'b1, 1'b0, 1);
        if (s) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'(a);
            nb = longint'(b);
        end
        ua = (na < 0) ? -na : na;
        ub = (nb < 0) ? -nb : nb;
        if ((ua >> 16) >= ub) return mk(16'hFFFF, 16'h0, 1'b0, 1'b1, 1);
        q = na / nb;
        r = na % nb;
        if (s && (q > 32767 || q < -32768)) return mk(16'hFFFF, 16'h0, 1'b0, 1'b1, DW + 2);
        e.qt = q[15:0];
        e.rm = r[15:0];
        return e;
    endfunction

    task automatic send(input logic [31:0] a, input logic [15:0] b, input logic s,
                        input exp_t e);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'(in_ready), 32'd1);
            return;
        end
        dd = a; dv = b; sgn = s; in_valid = 1'b1;
        sb.push_back(e);
        acc_cyc = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
        dd = $urandom; dv = 16'($urandom); sgn = ~s;
    endtask

    task automatic collect();
        exp_t e;
        int   guard = 0;
        while (!(out_valid && out_ready) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!(out_valid && out_ready)) begin
            check("collect_timeout", 32'(out_valid), 32'd1);
            return;
        end
        if (sb.size() == 0) begin
            check("sb_empty", 32'(out_valid), 32'd0);
            @(negedge clk);
            return;
        end
        e = sb.pop_front();
        check("qt", 32'(qt), 32'(e.qt));
        check("rm", 32'(rm), 32'(e.rm));
        check("dbz", 32'(dbz), 32'(e.dbz));
        check("ovf", 32'(ovf), 32'(e.ovf));
        check("lat", 32'(rise_cyc - acc_cyc), 32'(e.lat));
        @(negedge clk);
    endtask

    task automatic run(input logic [31:0] a, input logic [15:0] b, input logic s, input exp_t e);
        send(a, b, s, e);
        collect();
    endtask

    initial begin
        logic [31:0] ra;
        logic [15:0] rb;
        logic        rs;
        int          wait_n;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_qt", 32'(qt), 32'd0);
        check("rst_rm", 32'(rm), 32'd0);
        check("rst_flags", 32'({dbz, ovf}), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        run(32'h0001E240, 16'd1000, 1'b0, mk(16'h007B, 16'h01C8, 1'b0, 1'b0, 18));
        run(32'hFFFE1DC0, 16'd1000, 1'b1, mk(16'hFF85, 16'hFE38, 1'b0, 1'b0, 18));
        run(32'h0001E240, 16'hFC18, 1'b1, mk(16'hFF85, 16'h01C8, 1'b0, 1'b0, 18));
        run(32'hFFFE1DC0, 16'hFC18, 1'b1, mk(16'h007B, 16'hFE38, 1'b0, 1'b0, 18));
        run(32'h12345678, 16'h0000, 1'b0, mk(16'hFFFF, 16'h5678, 1'b1, 1'b0, 1));
        run(32'h00010000, 16'h0001, 1'b0, mk(16'hFFFF, 16'h0000, 1'b0, 1'b1, 1));
        run(32'hFFFF8000, 16'hFFFF, 1'b1, mk(16'hFFFF, 16'h0000, 1'b0, 1'b1, 18));
        run(32'hFFFF8000, 16'h0001, 1'b1, mk(16'h8000, 16'h0000, 1'b0, 1'b0, 18));
        run(32'hFFFE0001, 16'hFFFF, 1'b0, mk(16'hFFFF, 16'h0000, 1'b0, 1'b0, 18));
        run(32'h80000000, 16'h0001, 1'b1, mk(16'hFFFF, 16'h0000, 1'b0, 1'b1, 1));
        run(32'h00000000, 16'h0005, 1'b0, mk(16'h0000, 16'h0000, 1'b0, 1'b0, 18));

        for (int i = 0; i < 40; i++) begin
            ra = $urandom >> $urandom_range(0, 16);
            if (i % 3 == 0) ra = -ra;
            rb = 16'($urandom);
            rs = i[0];
            run(ra, rb, rs, model(ra, rb, rs));
        end

        // Back-pressure: result must hold while the consumer stalls.
        out_ready = 1'b0;
        send(32'd1000, 16'd7, 1'b0, mk(16'd142, 16'd6, 1'b0, 1'b0, 18));
        wait_n = 0;
        while (!out_valid && wait_n < 40) begin
            @(negedge clk);
            wait_n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_qt", 32'(qt), 32'd142);
            check("bp_rm", 32'(rm), 32'd6);
        end
        out_ready = 1'b1;
        collect();
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);

        // Reset while kreg==7.
        send(32'h0001E240, 16'd1000, 1'b0, mk(16'h007B, 16'h01C8, 1'b0, 1'b0, 18));
        repeat (8) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_qt", 32'(qt), 32'd0);
        check("mid_rst_rm", 32'(rm), 32'd0);
        check("mid_rst_flags", 32'({dbz, ovf}), 32'd0);
        run(32'd100, 16'd7, 1'b0, mk(16'd14, 16'd2, 1'b0, 1'b0, 18));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
